// File: rtl/xor_frame_checker.sv
// Streaming frame parity checker: XORs every accepted word of a frame into a
// column-parity word, then reduces it to one parity bit. Optional XOR_FRAME_CHECK_EN adds an expected-parity compare.
module xor_frame_checker #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    input  logic             s_odd,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_colpar,
    output logic             m_parity,
    output logic [CNT_W-1:0] m_count,
    output logic             m_ovf
`ifdef XOR_FRAME_CHECK_EN
    ,
    input  logic [WIDTH-1:0] s_check,
    output logic             m_error
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             mode_q, mode_d;
    logic             beat;

`ifdef XOR_FRAME_CHECK_EN
    logic [WIDTH-1:0] check_q, check_d;
`endif

    assign beat = s_valid && s_ready;

    // Next-state and accumulator update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        mode_d  = mode_q;
`ifdef XOR_FRAME_CHECK_EN
        check_d = check_q;
`endif
        case (state_q)
            IDLE: begin
                if (beat) begin
                    acc_d   = s_data;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    mode_d  = s_odd;
                    state_d = s_last ? HOLD : ACCUM;
`ifdef XOR_FRAME_CHECK_EN
                    if (s_last) check_d = s_check;
`endif
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d = acc_q ^ s_data;
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (s_last) begin
                        state_d = HOLD;
`ifdef XOR_FRAME_CHECK_EN
                        check_d = s_check;
`endif
                    end
                end
            end
            HOLD: begin
                // m_valid is always high in HOLD, so m_ready alone completes the handshake.
                if (m_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
`ifdef XOR_FRAME_CHECK_EN
                    check_d = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, accumulators and registered outputs loaded from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            mode_q   <= 1'b0;
            s_ready  <= 1'b1;
            m_valid  <= 1'b0;
            m_colpar <= '0;
            m_parity <= 1'b0;
            m_count  <= '0;
            m_ovf    <= 1'b0;
`ifdef XOR_FRAME_CHECK_EN
            check_q  <= '0;
            m_error  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            mode_q  <= mode_d;
            s_ready <= (state_d != HOLD);
            m_valid <= (state_d == HOLD);
            if (state_d == HOLD) begin
                m_colpar <= acc_d;
                m_parity <= (^acc_d) ^ mode_d;
                m_count  <= cnt_d;
                m_ovf    <= ovf_d;
            end else begin
                m_colpar <= '0;
                m_parity <= 1'b0;
                m_count  <= '0;
                m_ovf    <= 1'b0;
            end
`ifdef XOR_FRAME_CHECK_EN
            check_q <= check_d;
            m_error <= (state_d == HOLD) && (acc_d != check_d);
`endif
        end
    end

endmodule

// File: tb/tb_xor_frame_checker.sv
// Directed self-checking bench for xor_frame_checker (WIDTH=8, CNT_W=2).
module tb_xor_frame_checker;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic             s_odd;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_colpar;
    logic             m_parity;
    logic [CNT_W-1:0] m_count;
    logic             m_ovf;
`ifdef XOR_FRAME_CHECK_EN
    logic [WIDTH-1:0] s_check;
    logic             m_error;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    xor_frame_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_odd    (s_odd),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_colpar (m_colpar),
        .m_parity (m_parity),
        .m_count  (m_count),
        .m_ovf    (m_ovf)
`ifdef XOR_FRAME_CHECK_EN
        ,
        .s_check  (s_check),
        .m_error  (m_error)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for exactly one edge; the caller knows s_ready is high.
    task automatic beat(input logic [7:0] d, input logic last, input logic odd);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        s_odd   = odd;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic result(input string tag, input logic [7:0] colpar, input logic par,
                          input logic [1:0] cnt, input logic ovf);
        chk({tag, "_valid"},  32'(m_valid),  32'd1);
        chk({tag, "_ready"},  32'(s_ready),  32'd0);
        chk({tag, "_colpar"}, 32'(m_colpar), 32'(colpar));
        chk({tag, "_parity"}, 32'(m_parity), 32'(par));
        chk({tag, "_count"},  32'(m_count),  32'(cnt));
        chk({tag, "_ovf"},    32'(m_ovf),    32'(ovf));
    endtask

    task automatic drain(input string tag);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk({tag, "_drain_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_drain_ready"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        s_odd   = 1'b0;
        m_ready = 1'b0;
`ifdef XOR_FRAME_CHECK_EN
        s_check = '0;
`endif
        #12;
        chk("rst_ready",  32'(s_ready),  32'd1);
        chk("rst_valid",  32'(m_valid),  32'd0);
        chk("rst_colpar", 32'(m_colpar), 32'd0);
        chk("rst_parity", 32'(m_parity), 32'd0);
        chk("rst_count",  32'(m_count),  32'd0);
        chk("rst_ovf",    32'(m_ovf),    32'd0);
        rst_n = 1'b1;
        tick();

        // Even frame 0x0F,0xF0,0x01 -> 0xFE, seven ones
        beat(8'h0F, 1'b0, 1'b0);
        chk("even_mid_valid", 32'(m_valid), 32'd0);
        beat(8'hF0, 1'b0, 1'b0);
        beat(8'h01, 1'b1, 1'b0);
        result("even", 8'hFE, 1'b1, 2'd3, 1'b0);
        drain("even");

        // Single-word odd and even frames of 0x03
        beat(8'h03, 1'b1, 1'b1);
        result("odd1", 8'h03, 1'b1, 2'd1, 1'b0);
        drain("odd1");
        beat(8'h03, 1'b1, 1'b0);
        result("even1", 8'h03, 1'b0, 2'd1, 1'b0);
        drain("even1");

        // Mode sampled on first beat only: 0x01 (odd) then 0x02 (s_odd=0)
        beat(8'h01, 1'b0, 1'b1);
        beat(8'h02, 1'b1, 1'b0);
        result("mode", 8'h03, 1'b1, 2'd2, 1'b0);
        drain("mode");

        // Backpressure: result 0x81, then hold an offered 0x55 beat for 5 cycles
        beat(8'h80, 1'b0, 1'b0);
        beat(8'h01, 1'b1, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h55;
        s_last  = 1'b1;
        s_odd   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            result("bp", 8'h81, 1'b0, 2'd2, 1'b0);
            tick();
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("bp_hs_valid", 32'(m_valid), 32'd0);
        chk("bp_hs_ready", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        result("bp_next", 8'h55, 1'b0, 2'd1, 1'b0);
        drain("bp_next");

        // Saturation boundary: 3 words fill the counter, a 4th sets ovf
        for (int i = 0; i < 3; i++) beat(8'h11, i == 2, 1'b0);
        result("full", 8'h11, 1'b0, 2'd3, 1'b0);
        drain("full");
        for (int i = 0; i < 4; i++) beat(8'h22, i == 3, 1'b0);
        result("sat4", 8'h00, 1'b0, 2'd3, 1'b1);
        drain("sat4");
        for (int i = 0; i < 5; i++) beat(8'hFF, i == 4, 1'b0);
        result("sat5", 8'hFF, 1'b0, 2'd3, 1'b1);
        drain("sat5");
        beat(8'h07, 1'b1, 1'b0);
        result("ovf_clr", 8'h07, 1'b1, 2'd1, 1'b0);
        drain("ovf_clr");

        // Asynchronous reset mid-frame
        beat(8'h3C, 1'b0, 1'b1);
        beat(8'h0C, 1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rmid_valid", 32'(m_valid), 32'd0);
        chk("rmid_ready", 32'(s_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        tick();
        beat(8'hAA, 1'b1, 1'b0);
        result("rmid_new", 8'hAA, 1'b0, 2'd1, 1'b0);

        // Asynchronous reset while holding a result
        #3;
        rst_n = 1'b0;
        #1;
        chk("rhold_valid",  32'(m_valid),  32'd0);
        chk("rhold_ready",  32'(s_ready),  32'd1);
        chk("rhold_colpar", 32'(m_colpar), 32'd0);
        chk("rhold_count",  32'(m_count),  32'd0);
        #2;
        rst_n = 1'b1;
        tick();

`ifdef XOR_FRAME_CHECK_EN
        // Expected-parity compare: 0x12^0x34 = 0x26
        s_check = 8'h26;
        beat(8'h12, 1'b0, 1'b0);
        beat(8'h34, 1'b1, 1'b0);
        result("chk_ok", 8'h26, 1'b1, 2'd2, 1'b0);
        chk("chk_ok_error", 32'(m_error), 32'd0);
        drain("chk_ok");
        chk("chk_idle_error", 32'(m_error), 32'd0);
        s_check = 8'h27;
        beat(8'h12, 1'b0, 1'b0);
        beat(8'h34, 1'b1, 1'b0);
        chk("chk_bad_error", 32'(m_error), 32'd1);
        drain("chk_bad");
        chk("chk_bad_clr", 32'(m_error), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
